// File: rtl/axi_ni_outstanding_tracker.sv
// rtl/axi_ni_outstanding_tracker.sv - per-ID outstanding write/read tracker with issue gating
module axi_ni_outstanding_tracker #(
    parameter int MAX_SUPPORTED_IDS = 16,
    parameter int ID_WIDTH          = 4,
    parameter int CNT_WIDTH         = 4,
    parameter int MAX_PER_ID        = 8,
    parameter int TOT_WIDTH         = 6,
    parameter int MAX_TOTAL         = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wr_issue,
    input  logic [ID_WIDTH-1:0]          wr_issue_id,
    input  logic                         rd_issue,
    input  logic [ID_WIDTH-1:0]          rd_issue_id,
    input  logic [MAX_SUPPORTED_IDS-1:0] decr_outs_wr_cntr,
    input  logic [MAX_SUPPORTED_IDS-1:0] decr_outs_rd_cntr,
    output logic                         wr_issue_allowed,
    output logic                         rd_issue_allowed,
    output logic [MAX_SUPPORTED_IDS-1:0] response_awaited,
    output logic [TOT_WIDTH-1:0]         wr_total,
    output logic [TOT_WIDTH-1:0]         rd_total,
    output logic                         ni_idle,
    output logic                         err_overflow,
    output logic                         err_underflow
);

    localparam logic [CNT_WIDTH-1:0] PER_LIM = CNT_WIDTH'(MAX_PER_ID);
    localparam logic [TOT_WIDTH-1:0] TOT_LIM = TOT_WIDTH'(MAX_TOTAL);

    logic [CNT_WIDTH-1:0]         wr_cnt [MAX_SUPPORTED_IDS];
    logic [CNT_WIDTH-1:0]         rd_cnt [MAX_SUPPORTED_IDS];
    logic [MAX_SUPPORTED_IDS-1:0] wr_nz, rd_nz;
    logic [MAX_SUPPORTED_IDS-1:0] wr_inc, wr_dec, rd_inc, rd_dec;
    logic [TOT_WIDTH-1:0]         wr_dec_n, rd_dec_n;
    logic                         wr_ovf, rd_ovf, wr_udf, rd_udf;

    always_comb begin
        // Gating looks only at registered state; same-cycle retires do not bypass.
        wr_issue_allowed = (wr_cnt[wr_issue_id] < PER_LIM) && (wr_total < TOT_LIM);
        rd_issue_allowed = (rd_cnt[rd_issue_id] < PER_LIM) && (rd_total < TOT_LIM);
        wr_ovf   = wr_issue && !wr_issue_allowed;
        rd_ovf   = rd_issue && !rd_issue_allowed;
        wr_dec_n = '0;
        rd_dec_n = '0;
        for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
            wr_nz[i]  = (wr_cnt[i] != '0);
            rd_nz[i]  = (rd_cnt[i] != '0);
            wr_inc[i] = wr_issue && (wr_issue_id == ID_WIDTH'(i)) && wr_issue_allowed;
            rd_inc[i] = rd_issue && (rd_issue_id == ID_WIDTH'(i)) && rd_issue_allowed;
            wr_dec[i] = decr_outs_wr_cntr[i] && wr_nz[i];
            rd_dec[i] = decr_outs_rd_cntr[i] && rd_nz[i];
            wr_dec_n  = wr_dec_n + TOT_WIDTH'(wr_dec[i]);
            rd_dec_n  = rd_dec_n + TOT_WIDTH'(rd_dec[i]);
        end
        wr_udf           = |(decr_outs_wr_cntr & ~wr_nz);
        rd_udf           = |(decr_outs_rd_cntr & ~rd_nz);
        response_awaited = wr_nz | rd_nz;
        ni_idle          = (wr_total == '0) && (rd_total == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
                wr_cnt[i] <= '0;
                rd_cnt[i] <= '0;
            end
            wr_total      <= '0;
            rd_total      <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_SUPPORTED_IDS; i++) begin
                if (wr_inc[i] && !wr_dec[i])
                    wr_cnt[i] <= wr_cnt[i] + 1'b1;
                else if (wr_dec[i] && !wr_inc[i])
                    wr_cnt[i] <= wr_cnt[i] - 1'b1;
                if (rd_inc[i] && !rd_dec[i])
                    rd_cnt[i] <= rd_cnt[i] + 1'b1;
                else if (rd_dec[i] && !rd_inc[i])
                    rd_cnt[i] <= rd_cnt[i] - 1'b1;
            end
            wr_total <= wr_total + TOT_WIDTH'(|wr_inc) - wr_dec_n;
            rd_total <= rd_total + TOT_WIDTH'(|rd_inc) - rd_dec_n;
            if (wr_ovf || rd_ovf)
                err_overflow <= 1'b1;
            if (wr_udf || rd_udf)
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_ni_outstanding_tracker.sv
// tb/tb_axi_ni_outstanding_tracker.sv - directed bench for axi_ni_outstanding_tracker
module tb_axi_ni_outstanding_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_issue, rd_issue;
    logic [3:0]  wr_issue_id, rd_issue_id;
    logic [15:0] decr_outs_wr_cntr, decr_outs_rd_cntr;
    logic        wr_issue_allowed, rd_issue_allowed;
    logic [15:0] response_awaited;
    logic [5:0]  wr_total, rd_total;
    logic        ni_idle, err_overflow, err_underflow;

    int tests_run    = 0;
    int tests_failed = 0;

    axi_ni_outstanding_tracker dut (
        .clk               (clk),
        .rst               (rst),
        .wr_issue          (wr_issue),
        .wr_issue_id       (wr_issue_id),
        .rd_issue          (rd_issue),
        .rd_issue_id       (rd_issue_id),
        .decr_outs_wr_cntr (decr_outs_wr_cntr),
        .decr_outs_rd_cntr (decr_outs_rd_cntr),
        .wr_issue_allowed  (wr_issue_allowed),
        .rd_issue_allowed  (rd_issue_allowed),
        .response_awaited  (response_awaited),
        .wr_total          (wr_total),
        .rd_total          (rd_total),
        .ni_idle           (ni_idle),
        .err_overflow      (err_overflow),
        .err_underflow     (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_issue = 1'b0; wr_issue_id = '0;
        rd_issue = 1'b0; rd_issue_id = '0;
        decr_outs_wr_cntr = '0; decr_outs_rd_cntr = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            wr_issue = 1'($urandom); wr_issue_id = 4'($urandom);
            rd_issue = 1'($urandom); rd_issue_id = 4'($urandom);
            decr_outs_wr_cntr = 16'($urandom); decr_outs_rd_cntr = 16'($urandom);
            tick();
        end
        clear_inputs();
        #1;
        tests_run++;
        if ({wr_total, rd_total} !== 12'h000) begin
            tests_failed++; $display("FAIL reset_totals: got %h expected 000", {wr_total, rd_total});
        end
        tests_run++;
        if ({ni_idle, wr_issue_allowed, rd_issue_allowed} !== 3'b111) begin
            tests_failed++; $display("FAIL reset_idle_allow: got %b expected 111", {ni_idle, wr_issue_allowed, rd_issue_allowed});
        end
        tests_run++;
        if (response_awaited !== 16'h0000) begin
            tests_failed++; $display("FAIL reset_awaited: got %h expected 0000", response_awaited);
        end
        tests_run++;
        if ({err_overflow, err_underflow} !== 2'b00) begin
            tests_failed++; $display("FAIL reset_errors: got %b expected 00", {err_overflow, err_underflow});
        end
        rst = 1'b0;
    endtask

    task automatic test_round_trip();
        int high = 0;
        do_reset();
        wr_issue = 1'b1; wr_issue_id = 4'd3;
        tick();
        wr_issue = 1'b0;
        tests_run++;
        if (wr_total !== 6'd1 || ni_idle !== 1'b0) begin
            tests_failed++; $display("FAIL rt_issue: total=%0d idle=%b expected 1 0", wr_total, ni_idle);
        end
        for (int k = 0; k < 5; k++) begin
            if (response_awaited == 16'h0008) high++;
            if (k == 4) decr_outs_wr_cntr = 16'h0008;
            tick();
        end
        decr_outs_wr_cntr = '0;
        tests_run++;
        if (high != 5) begin
            tests_failed++; $display("FAIL rt_awaited_cycles: got %0d expected 5", high);
        end
        tests_run++;
        if (response_awaited !== 16'h0000 || wr_total !== 6'd0 || ni_idle !== 1'b1) begin
            tests_failed++; $display("FAIL rt_retire: aw=%h total=%0d idle=%b expected 0000 0 1", response_awaited, wr_total, ni_idle);
        end
        tests_run++;
        if (err_underflow !== 1'b0) begin
            tests_failed++; $display("FAIL rt_no_underflow: got %b expected 0", err_underflow);
        end
    endtask

    task automatic test_per_id_limit();
        do_reset();
        rd_issue = 1'b1; rd_issue_id = 4'd5;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) begin
                tests_run++;
                if (rd_issue_allowed !== 1'b1) begin
                    tests_failed++; $display("FAIL pid_before_limit: got %b expected 1", rd_issue_allowed);
                end
            end
            tick();
        end
        tests_run++;
        if (rd_issue_allowed !== 1'b0 || rd_total !== 6'd8) begin
            tests_failed++; $display("FAIL pid_at_limit: allow=%b total=%0d expected 0 8", rd_issue_allowed, rd_total);
        end
        tick();
        tests_run++;
        if (err_overflow !== 1'b1 || rd_total !== 6'd8 || response_awaited !== 16'h0020) begin
            tests_failed++; $display("FAIL pid_ninth: ovf=%b total=%0d aw=%h expected 1 8 0020", err_overflow, rd_total, response_awaited);
        end
        rd_issue = 1'b0; rd_issue_id = 4'd6; wr_issue_id = 4'd5;
        #1;
        tests_run++;
        if (rd_issue_allowed !== 1'b1 || wr_issue_allowed !== 1'b1) begin
            tests_failed++; $display("FAIL pid_other_ids: rd=%b wr=%b expected 1 1", rd_issue_allowed, wr_issue_allowed);
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] ids [5] = '{4'd2, 4'd2, 4'd2, 4'd0, 4'd1};
        do_reset();
        wr_issue = 1'b1;
        foreach (ids[k]) begin
            wr_issue_id = ids[k];
            tick();
        end
        wr_issue_id = 4'd2; decr_outs_wr_cntr = 16'h0004;
        tick();
        wr_issue = 1'b0; decr_outs_wr_cntr = '0;
        tests_run++;
        if (wr_total !== 6'd5 || response_awaited !== 16'h0007) begin
            tests_failed++; $display("FAIL sim_inc_dec: total=%0d aw=%h expected 5 0007", wr_total, response_awaited);
        end
        decr_outs_wr_cntr = 16'h0003;
        tick();
        tests_run++;
        if (wr_total !== 6'd3 || response_awaited !== 16'h0004) begin
            tests_failed++; $display("FAIL sim_multi_dec: total=%0d aw=%h expected 3 0004", wr_total, response_awaited);
        end
        decr_outs_wr_cntr = 16'h0004;
        tick(); tick();
        tests_run++;
        if (wr_total !== 6'd1 || response_awaited !== 16'h0004) begin
            tests_failed++; $display("FAIL sim_cnt2_left: total=%0d aw=%h expected 1 0004", wr_total, response_awaited);
        end
        tick();
        decr_outs_wr_cntr = '0;
        tests_run++;
        if (wr_total !== 6'd0 || response_awaited !== 16'h0000 || err_underflow !== 1'b0) begin
            tests_failed++; $display("FAIL sim_drained: total=%0d aw=%h udf=%b expected 0 0000 0", wr_total, response_awaited, err_underflow);
        end
        wr_issue = 1'b1; wr_issue_id = 4'd7; rd_issue = 1'b1; rd_issue_id = 4'd9;
        tick();
        clear_inputs();
        tests_run++;
        if (wr_total !== 6'd1 || rd_total !== 6'd1 || response_awaited !== 16'h0280) begin
            tests_failed++; $display("FAIL sim_wr_rd: wr=%0d rd=%0d aw=%h expected 1 1 0280", wr_total, rd_total, response_awaited);
        end
    endtask

    task automatic test_global_limit();
        do_reset();
        wr_issue = 1'b1;
        for (int k = 0; k < 32; k++) begin
            wr_issue_id = 4'(k / 2);
            tick();
        end
        wr_issue = 1'b0;
        tests_run++;
        if (wr_total !== 6'd32 || response_awaited !== 16'hFFFF) begin
            tests_failed++; $display("FAIL gl_total: total=%0d aw=%h expected 32 ffff", wr_total, response_awaited);
        end
        for (int id = 0; id < 16; id++) begin
            wr_issue_id = 4'(id);
            #1;
            tests_run++;
            if (wr_issue_allowed !== 1'b0) begin
                tests_failed++; $display("FAIL gl_blocked id=%0d: got %b expected 0", id, wr_issue_allowed);
            end
        end
        rd_issue_id = 4'd4;
        #1;
        tests_run++;
        if (rd_issue_allowed !== 1'b1) begin
            tests_failed++; $display("FAIL gl_rd_free: got %b expected 1", rd_issue_allowed);
        end
        decr_outs_wr_cntr = 16'h0001; wr_issue_id = 4'd5;
        #1;
        tests_run++;
        if (wr_issue_allowed !== 1'b0) begin
            tests_failed++; $display("FAIL gl_no_bypass: got %b expected 0", wr_issue_allowed);
        end
        tick();
        decr_outs_wr_cntr = '0;
        tests_run++;
        if (wr_total !== 6'd31 || wr_issue_allowed !== 1'b1 || err_overflow !== 1'b0) begin
            tests_failed++; $display("FAIL gl_reopen: total=%0d allow=%b ovf=%b expected 31 1 0", wr_total, wr_issue_allowed, err_overflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        decr_outs_rd_cntr = 16'h0001;
        tick();
        decr_outs_rd_cntr = '0;
        tests_run++;
        if (err_underflow !== 1'b1 || rd_total !== 6'd0 || ni_idle !== 1'b1 || response_awaited !== 16'h0000) begin
            tests_failed++; $display("FAIL udf_set: udf=%b total=%0d idle=%b aw=%h expected 1 0 1 0000", err_underflow, rd_total, ni_idle, response_awaited);
        end
        tick(); tick(); tick();
        tests_run++;
        if (err_underflow !== 1'b1) begin
            tests_failed++; $display("FAIL udf_sticky: got %b expected 1", err_underflow);
        end
        do_reset();
        tests_run++;
        if (err_underflow !== 1'b0) begin
            tests_failed++; $display("FAIL udf_cleared: got %b expected 0", err_underflow);
        end
    endtask

    task automatic test_mid_traffic_reset();
        do_reset();
        wr_issue = 1'b1; wr_issue_id = 4'd10;
        tick();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        decr_outs_wr_cntr = 16'h0400;
        tick();
        decr_outs_wr_cntr = '0;
        tests_run++;
        if (wr_total !== 6'd0 || response_awaited !== 16'h0000 || err_underflow !== 1'b1) begin
            tests_failed++; $display("FAIL mid_rst: total=%0d aw=%h udf=%b expected 0 0000 1", wr_total, response_awaited, err_underflow);
        end
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        test_reset();
        test_round_trip();
        test_per_id_limit();
        test_simultaneous();
        test_global_limit();
        test_underflow();
        test_mid_traffic_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/axi_ni_outstanding_tracker.md
# axi_ni_outstanding_tracker

Per-ID outstanding-transaction tracker for the AXI initiator NI. It counts write and read requests issued into the NoC per AXI ID and retires them on the one-hot decrement strobes from the response FSM. It drives that FSM's `response_awaited` vector and gates new requests on the request side when a per-ID or global limit is reached.

## Interface

Parameters:

- `MAX_SUPPORTED_IDS`, 16: number of tracked AXI IDs.
- `ID_WIDTH`, 4: width of the issue ID; equals log2(`MAX_SUPPORTED_IDS`).
- `CNT_WIDTH`, 4: per-ID counter width.
- `MAX_PER_ID`, 8: per-ID limit, applied to each direction separately; must be ≤ 2^`CNT_WIDTH` − 1.
- `TOT_WIDTH`, 6: total-counter width.
- `MAX_TOTAL`, 32: global limit, applied to each direction separately; must be ≤ 2^`TOT_WIDTH` − 1.

Ports (reset `rst`, synchronous, active-high; clock `clk`):

- `clk`  in  1  clock.
- `rst`  in  1  synchronous active-high reset.
- `wr_issue`  in  1  write request accepted into NoC this cycle.
- `wr_issue_id`  in  `ID_WIDTH`  ID of that write.
- `rd_issue`  in  1  read request accepted this cycle.
- `rd_issue_id`  in  `ID_WIDTH`  ID of that read.
- `decr_outs_wr_cntr`  in  `MAX_SUPPORTED_IDS`  write-retire strobes, one bit per ID.
- `decr_outs_rd_cntr`  in  `MAX_SUPPORTED_IDS`  read-retire strobes, one bit per ID.
- `wr_issue_allowed`  out  1  a write on `wr_issue_id` may issue.
- `rd_issue_allowed`  out  1  a read on `rd_issue_id` may issue.
- `response_awaited`  out  `MAX_SUPPORTED_IDS`  bit i = ID i has any outstanding write or read.
- `wr_total`  out  `TOT_WIDTH`  writes outstanding.
- `rd_total`  out  `TOT_WIDTH`  reads outstanding.
- `ni_idle`  out  1  nothing outstanding.
- `err_overflow`  out  1  sticky: an issue arrived while not allowed.
- `err_underflow`  out  1  sticky: a decrement arrived on a zero counter.

## Operation

- State:
  - `wr_cnt[i]` and `rd_cnt[i]`, each `CNT_WIDTH` bits, for i = 0..`MAX_SUPPORTED_IDS`−1.
  - `wr_total`, `rd_total` registers.
  - Two sticky error flags.
- Reset values: all counters 0; `response_awaited` = 0; `ni_idle` = 1; `wr_issue_allowed` = `rd_issue_allowed` = 1; both error flags 0.
- Write counter update per ID i, each cycle:
  - inc = `wr_issue` & (`wr_issue_id` == i) & `wr_issue_allowed`.
  - dec = `decr_outs_wr_cntr[i]` & (`wr_cnt[i]` != 0).
  - inc & dec: counter holds.
  - inc only: +1.
  - dec only: −1.
- Read counters follow the identical rule with the read-side signals.
- `wr_total` update: +1 if any write inc; minus popcount of write decs (only valid decs count). Net change is applied in one cycle. `rd_total` likewise.
- Issue gating:
  - `wr_issue_allowed` = (`wr_cnt[wr_issue_id]` < `MAX_PER_ID`) & (`wr_total` < `MAX_TOTAL`).
  - `rd_issue_allowed` is the read-side equivalent.
  - Both are combinational from registered state plus the issue ID. There is no bypass from same-cycle decrements.
- Errors:
  - `wr_issue` while `wr_issue_allowed` = 0 is ignored (no count change) and sets `err_overflow`. Same for reads.
  - A decrement bit on a zero counter is ignored and sets `err_underflow`.
  - Both flags clear only on `rst`.
- Outputs derived from state:
  - `response_awaited[i]` = (`wr_cnt[i]` != 0) | (`rd_cnt[i]` != 0).
  - `ni_idle` = (`wr_total` == 0) & (`rd_total` == 0).
- Reads and writes are fully independent. Both may issue, and any decrement bits may assert, in the same cycle.

## Timing

- An issue or decrement at edge N is visible on counters, totals, `response_awaited` and `ni_idle` after edge N. Latency is 1 cycle, with no further pipelining.
- `response_awaited[i]` rises the cycle after the first issue on ID i. It falls the cycle after the retiring decrement of the last outstanding transaction.
- An allow signal deasserts the cycle after the limit is reached. It reasserts the cycle after a decrement takes that count below the limit.
- Multiple decrement bits in one cycle (across IDs) are all honoured.
- `rst` asserted mid-traffic clears every counter at the next edge. In-flight responses then decrement zero counters and raise `err_underflow`; this is expected and flagged.

## Test plan

- Reset: assert `rst` 2 cycles with random inputs → all counters 0, `ni_idle` = 1, both allows 1, `response_awaited` = 0, both error flags 0.
- Single round trip: `wr_issue` id 3, then 4 cycles later `decr_outs_wr_cntr` = 0x0008 → `response_awaited` = 0x0008 for exactly 5 cycles; `wr_total` 1 then 0; `ni_idle` returns to 1.
- Per-ID limit: 8 `rd_issue` on id 5 → `rd_issue_allowed` (id 5) = 0 after the 8th; a 9th issue sets `err_overflow` and `rd_cnt[5]` stays 8; id 6 is still allowed.
- Simultaneous events: with `wr_cnt[2]` = 3, issue id 2 and decrement bit 2 in the same cycle → `wr_cnt[2]` = 3, `wr_total` unchanged; also decrement bits 0 and 1 (counts 1 each) in one cycle → `wr_total` −2.
- Global limit: 32 writes spread over IDs 0–15, 2 each → `wr_issue_allowed` = 0 for every ID; one decrement → allowed again the next cycle.
- Underflow: `decr_outs_rd_cntr` = 0x0001 with `rd_cnt[0]` = 0 → counters unchanged, `err_underflow` = 1 and stays set until `rst`.
